// File: rtl/seg_display_ctrl_pkg.sv
// rtl/seg_display_ctrl_pkg.sv - shared encodings for the 7-segment display controller
package seg_display_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SYSCALL = 3'd0,
    OP_CYCLE   = 3'd1,
    OP_UNCOND  = 3'd2,
    OP_COND    = 3'd3,
    OP_RAM     = 3'd4,
    OP_PC      = 3'd5,
    OP_INSTR   = 3'd6,
    OP_ADDR    = 3'd7
  } display_op_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is never lit.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - RAM display read port and multiplexed display outputs
interface seg_display_ctrl_if;

  logic [9:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [31:0] shown_value;

  modport master (
    output ram_rd_addr,
    output an,
    output seg,
    output shown_value,
    input  ram_rd_data
  );

  modport slave (
    input  ram_rd_addr,
    input  an,
    input  seg,
    input  shown_value,
    output ram_rd_data
  );

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment pattern
module hex_to_seg7
  import seg_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - 8-digit hex scan of a selected CPU value, resampled once per frame
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          display_op,
  input  logic [9:0]          ram_display_addr,
  input  logic [31:0]         pc,
  input  logic [31:0]         instr,
  input  logic [31:0]         cycle_cnt,
  input  logic [31:0]         uncond_cnt,
  input  logic [31:0]         cond_cnt,
  input  logic [31:0]         syscall_val,
  seg_display_ctrl_if.master  disp
);

  localparam int TICK = CLK_HZ / DIGIT_HZ;
  localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;

  logic [PW-1:0] prescaler;
  logic [2:0]    digit;
  logic          tick_wrap;
  logic          frame_end;
  logic [1:0]    state;
  display_op_e   op_q;
  logic [31:0]   src_value;
  logic [3:0]    cur_nibble;
  logic [7:0]    cur_pattern;

  assign tick_wrap = (prescaler == PW'(TICK - 1));
  assign frame_end = tick_wrap && (digit == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit     <= '0;
    end else if (tick_wrap) begin
      prescaler <= '0;
      digit     <= digit + 3'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Op 7 shows the latched address so it cannot change mid-frame either.
  always_comb begin
    src_value = syscall_val;
    case (op_q)
      OP_SYSCALL: src_value = syscall_val;
      OP_CYCLE:   src_value = cycle_cnt;
      OP_UNCOND:  src_value = uncond_cnt;
      OP_COND:    src_value = cond_cnt;
      OP_RAM:     src_value = disp.ram_rd_data;
      OP_PC:      src_value = pc;
      OP_INSTR:   src_value = instr;
      OP_ADDR:    src_value = {22'b0, disp.ram_rd_addr};
      default:    src_value = syscall_val;
    endcase
  end

  // Starting in S_ADDR makes the first fetch begin right after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_ADDR;
      op_q             <= OP_SYSCALL;
      disp.ram_rd_addr <= '0;
      disp.shown_value <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_end) state <= S_ADDR;
        end
        S_ADDR: begin
          disp.ram_rd_addr <= ram_display_addr;
          op_q             <= display_op_e'(display_op);
          state            <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          disp.shown_value <= src_value;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cur_nibble = disp.shown_value[4*digit +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp.an  <= 8'hFF;
      disp.seg <= SEG_BLANK;
    end else begin
      disp.an  <= ~(8'b1 << digit);
      disp.seg <= cur_pattern;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - scoreboard bench for seg_display_ctrl with TICK=8
module tb_seg_display_ctrl;

  localparam int TICK  = 8;
  localparam int FRAME = 8 * TICK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  display_op = 3'd5;
  logic [9:0]  ram_display_addr = '0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] cycle_cnt = '0;
  logic [31:0] uncond_cnt = '0;
  logic [31:0] cond_cnt = '0;
  logic [31:0] syscall_val = '0;
  logic [31:0] mem [0:1023];
  logic [7:0]  hex_tab [16];

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] val;
    int          k;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   k = 0;

  seg_display_ctrl_if dif ();

  seg_display_ctrl #(.CLK_HZ(8), .DIGIT_HZ(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .display_op       (display_op),
    .ram_display_addr (ram_display_addr),
    .pc               (pc),
    .instr            (instr),
    .cycle_cnt        (cycle_cnt),
    .uncond_cnt       (uncond_cnt),
    .cond_cnt         (cond_cnt),
    .syscall_val      (syscall_val),
    .disp             (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dif.ram_rd_data <= mem[dif.ram_rd_addr];

  function automatic logic [31:0] pick(input logic [2:0] op, input logic [9:0] a);
    case (op)
      3'd0: return syscall_val;
      3'd1: return cycle_cnt;
      3'd2: return uncond_cnt;
      3'd3: return cond_cnt;
      3'd4: return mem[a];
      3'd5: return pc;
      3'd6: return instr;
      default: return {22'd0, a};
    endcase
  endfunction

  // Reference: k counts clocks since reset release; a frame is FRAME clocks,
  // the source is captured at frame position 1 and shown from position 3.
  initial begin
    exp_t        e_m;
    logic [31:0] m_val;
    logic [2:0]  m_op;
    logic [9:0]  m_addr;
    int          d;
    m_val  = '0;
    m_op   = '0;
    m_addr = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        k       = 0;
        m_val   = '0;
        e_m.an  = 8'hFF;
        e_m.seg = 8'hFF;
      end else begin
        k       = k + 1;
        d       = ((k - 1) / TICK) % 8;
        e_m.an  = ~(8'h01 << d);
        e_m.seg = hex_tab[m_val[4*d +: 4]];
        if (k % FRAME == 1) begin
          m_op   = display_op;
          m_addr = ram_display_addr;
        end
        if (k % FRAME == 3) m_val = pick(m_op, m_addr);
      end
      e_m.val = m_val;
      e_m.k   = k;
      exp_q.push_back(e_m);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int kk);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, kk, act, exp);
    end
  endtask

  initial begin
    exp_t e_c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e_c = exp_q.pop_front();
        check("an", {24'd0, dif.an}, {24'd0, e_c.an}, e_c.k);
        check("seg", {24'd0, dif.seg}, {24'd0, e_c.seg}, e_c.k);
        check("shown_value", dif.shown_value, e_c.val, e_c.k);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cycle_cnt = cycle_cnt + 32'd1;
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % FRAME) != p && n < 3 * FRAME);
    n_cmp++;
    if ((k % FRAME) != p) begin
      n_err++;
      $display("FAIL wait_pos: frame position %0d, expected %0d", k % FRAME, p);
    end
  endtask

  task automatic jiggle(input bit allow_op);
    case ($urandom_range(0, 15))
      0: pc = $urandom;
      1: instr = $urandom;
      2: uncond_cnt = $urandom;
      3: cond_cnt = $urandom;
      4: syscall_val = $urandom;
      5: ram_display_addr = 10'($urandom);
      6: if (allow_op) display_op = 3'($urandom);
      default: ;
    endcase
  endtask

  initial begin
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[3] = 32'hDEADBEEF;
    uncond_cnt  = 32'h0000_0A5C;
    cond_cnt    = 32'h1234_5678;
    syscall_val = 32'h9ABC_DEF0;
    instr       = 32'h0221_8020;

    // Reset, then PC display for a full frame.
    rst = 1'b1;
    display_op = 3'd5;
    pc = 32'h0040_0010;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME + 8) @(negedge clk);

    // RAM word 3.
    display_op = 3'd4;
    ram_display_addr = 10'h003;
    wait_pos(1);
    wait_pos(0);

    // Op change during the wait state is ignored until the next frame.
    display_op = 3'd1;
    wait_pos(1);
    display_op = 3'd2;
    ram_display_addr = 10'h155;
    wait_pos(0);
    wait_pos(10);

    // Reset pulse in the middle of digit 4.
    display_op = 3'd5;
    wait_pos(35);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_pos(20);

    // Address display at the top of the range.
    display_op = 3'd7;
    ram_display_addr = 10'h3FF;
    wait_pos(0);
    wait_pos(40);

    // Every op once, with inputs wandering while the frame scans.
    for (int f = 0; f < 8; f++) begin
      wait_pos(62);
      display_op = 3'((f * 5 + 3) % 8);
      ram_display_addr = 10'($urandom);
      repeat (FRAME - 4) begin
        @(negedge clk);
        jiggle((k % FRAME) > 2 && (k % FRAME) < 60);
      end
    end

    wait_pos($urandom_range(4, 50));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (FRAME + 10) begin
      @(negedge clk);
      jiggle(1'b0);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
